regfile_wb_arbiter: RTL and testbench

Write-back arbiter that shares the register file's single write port (write enable, 5-bit write address, 32-bit write data) among three result producers. The producers are the main pipeline WB stage, the multi-cycle multiply/divide unit, and the load/CP0 unit. It sits between those producers and the register file. It grants one requester per cycle using round-robin, with a valid/ready handshake, and registers the selected write onto the port. The register file commits on the falling edge of the cycle in which the port is driven.

---
 rtl/regfile_wb_arbiter.sv | 118 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_arbiter
//  Purpose  : Shares the register file's single write port among three result
//             producers (WB stage, mul/div unit, load/CP0 unit). One requester
//             is granted per cycle, in round-robin order, and its write is
//             registered onto the port for the following cycle.
//  Ports    : clk, resetn       - clock, asynchronous active-low reset
//             req_valid/ready   - per-requester handshake (ready is one-hot)
//             req_addr/data     - packed per-requester destination and data
//             wb_hold           - blocks all grants while high
//             wr_we/addr/data   - registered register-file write port
//             grant_id          - registered index of the requester on the port
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 32,
    parameter int AW   = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    input  logic              wb_hold,
    output logic              wr_we,
    output logic [AW-1:0]     wr_addr,
    output logic [DW-1:0]     wr_data,
    output logic [1:0]        grant_id
);

    // Highest-priority requester for the next arbitration (0..2).
    logic [1:0]    rr_ptr;

    logic [1:0]    idx0;
    logic [1:0]    idx1;
    logic [1:0]    idx2;
    logic [1:0]    win;
    logic          any_grant;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;

    // Modulo-3 increment of a requester index.
    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign idx0 = rr_ptr;
    assign idx1 = next_ptr(idx0);
    assign idx2 = next_ptr(idx1);

    // Rotating priority search starting at rr_ptr. Gated by resetn so that
    // no requester sees a grant while the block is held in reset.
    always_comb begin
        win       = 2'd0;
        any_grant = 1'b0;
        req_ready = '0;
        if (resetn && !wb_hold) begin
            if (req_valid[idx0]) begin
                win       = idx0;
                any_grant = 1'b1;
            end else if (req_valid[idx1]) begin
                win       = idx1;
                any_grant = 1'b1;
            end else if (req_valid[idx2]) begin
                win       = idx2;
                any_grant = 1'b1;
            end
        end
        if (any_grant) begin
            req_ready[win] = 1'b1;
        end
    end

    // Write-port mux for the winning requester.
    always_comb begin
        sel_addr = req_addr[0*AW +: AW];
        sel_data = req_data[0*DW +: DW];
        case (win)
            2'd1: begin
                sel_addr = req_addr[1*AW +: AW];
                sel_data = req_data[1*DW +: DW];
            end
            2'd2: begin
                sel_addr = req_addr[2*AW +: AW];
                sel_data = req_data[2*DW +: DW];
            end
            default: begin
                sel_addr = req_addr[0*AW +: AW];
                sel_data = req_data[0*DW +: DW];
            end
        endcase
    end

    // Registered write port. A write to $0 still consumes the grant and
    // advances the pointer, but never raises the write enable.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr   <= 2'd0;
            wr_we    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            grant_id <= 2'd0;
        end else if (any_grant) begin
            wr_we    <= (sel_addr != '0);
            wr_addr  <= sel_addr;
            wr_data  <= sel_data;
            grant_id <= win;
            rr_ptr   <= next_ptr(win);
        end else begin
            wr_we    <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_wb_arbiter
//  Purpose  : Self-checking bench for regfile_wb_arbiter. Directed stimulus
//             with hand-computed grants; each accepted non-$0 write is queued
//             and a monitor compares it when the port shows wr_we.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int NREQ = 3;
    localparam int DW   = 32;
    localparam int AW   = 5;

    logic              clk;
    logic              resetn;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              wb_hold;
    logic              wr_we;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [1:0]        grant_id;

    int checks = 0;
    int errors = 0;

    // Expected port write: {grant_id, addr, data}
    logic [2+AW+DW-1:0] exp_q[$];

    regfile_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wb_hold   (wb_hold),
        .wr_we     (wr_we),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .grant_id  (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    // Check the expected grant for the current inputs, queue the resulting
    // port write (if not to $0), then advance past the next rising edge.
    task automatic issue(input logic [2:0] exp_ready);
        int idx;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        #1;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        idx = -1;
        case (exp_ready)
            3'b001: idx = 0;
            3'b010: idx = 1;
            3'b100: idx = 2;
            default: idx = -1;
        endcase
        if (idx >= 0) begin
            a = req_addr[idx*AW +: AW];
            d = req_data[idx*DW +: DW];
            if (a != '0) exp_q.push_back({2'(idx), a, d});
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every visible port write must match the oldest queued grant.
    always @(negedge clk) begin
        if (resetn && wr_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 64'(wr_addr), 64'h0);
            end else begin
                logic [2+AW+DW-1:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", 64'(wr_addr), 64'(e[DW +: AW]));
                chk("wr_data", 64'(wr_data), 64'(e[DW-1:0]));
                chk("grant_id", 64'(grant_id), 64'(e[DW+AW +: 2]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn    = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        wb_hold   = 1'b0;

        // Reset state, and no grants while in reset
        #12;
        chk("rst_wr_we", 64'(wr_we), 64'h0);
        chk("rst_wr_addr", 64'(wr_addr), 64'h0);
        chk("rst_wr_data", 64'(wr_data), 64'h0);
        chk("rst_grant_id", 64'(grant_id), 64'h0);
        req_valid = 3'b111;
        #1;
        chk("rst_ready", 64'(req_ready), 64'h0);
        req_valid = 3'b000;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Single request from requester 0 -> rr_ptr becomes 1
        set_req(0, 5'd8, 32'h1234_5678);
        req_valid = 3'b001;
        issue(3'b001);
        req_valid = 3'b000;

        // Rotation with gaps from rr_ptr=1: 2 wins over 0, then 0
        set_req(0, 5'd9, 32'h0000_0009);
        set_req(2, 5'd10, 32'h0000_000A);
        req_valid = 3'b101;
        issue(3'b100);
        req_valid = 3'b001;
        issue(3'b001);
        set_req(0, 5'd11, 32'h0000_000B);
        issue(3'b001);
        set_req(0, 5'd12, 32'h0000_000C);
        issue(3'b001);
        // rr_ptr=1; a lone requester 2 moves it to 0
        set_req(2, 5'd13, 32'h0000_000D);
        req_valid = 3'b100;
        issue(3'b100);

        // Round-robin fairness from rr_ptr=0
        set_req(0, 5'd1, 32'hA000_0001);
        set_req(1, 5'd2, 32'hB000_0002);
        set_req(2, 5'd3, 32'hC000_0003);
        req_valid = 3'b111;
        issue(3'b001);
        set_req(0, 5'd1, 32'hA000_0011);
        issue(3'b010);
        set_req(1, 5'd2, 32'hB000_0012);
        issue(3'b100);
        set_req(2, 5'd3, 32'hC000_0013);
        issue(3'b001);
        issue(3'b010);
        issue(3'b100);
        req_valid = 3'b000;

        // $0 suppression: accepted, no write, pointer advances to 2
        set_req(1, 5'd0, 32'hDEAD_BEEF);
        req_valid = 3'b010;
        issue(3'b010);
        chk("zero_no_we", 64'(wr_we), 64'h0);
        set_req(0, 5'd4, 32'h0000_0044);
        set_req(1, 5'd5, 32'h0000_0055);
        set_req(2, 5'd6, 32'h0000_0066);
        req_valid = 3'b111;
        issue(3'b100);

        // wb_hold blocks grants; write from previous cycle still appears
        req_valid = 3'b010;
        wb_hold   = 1'b1;
        issue(3'b000);
        chk("hold_we1", 64'(wr_we), 64'h0);
        issue(3'b000);
        chk("hold_we2", 64'(wr_we), 64'h0);
        issue(3'b000);
        chk("hold_we3", 64'(wr_we), 64'h0);
        wb_hold = 1'b0;
        issue(3'b010);
        req_valid = 3'b000;

        // Async reset mid-burst (rr_ptr=2)
        set_req(0, 5'd21, 32'h2100_0000);
        set_req(1, 5'd22, 32'h2200_0000);
        set_req(2, 5'd23, 32'h2300_0000);
        req_valid = 3'b111;
        issue(3'b100);
        issue(3'b001);
        #1;
        chk("pre_rst_ready", 64'(req_ready), 64'b010);
        @(posedge clk);
        #1;
        chk("pre_rst_we", 64'(wr_we), 64'h1);
        resetn = 1'b0;
        #1;
        chk("mid_rst_we", 64'(wr_we), 64'h0);
        chk("mid_rst_addr", 64'(wr_addr), 64'h0);
        chk("mid_rst_data", 64'(wr_data), 64'h0);
        chk("mid_rst_gid", 64'(grant_id), 64'h0);
        chk("mid_rst_ready", 64'(req_ready), 64'h0);
        resetn = 1'b1;
        issue(3'b001);
        req_valid = 3'b000;

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 64'(exp_q.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
